// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared constants and FSM type for the AES-128 round sequencer
package aes_ctrl_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;
  localparam int AES_RND_W = $clog2(AES_NR + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - block, key-schedule and round-function handshakes of the AES sequencer
interface aes_round_ctrl_if;
  import aes_ctrl_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [AES_BLK_W-1:0] in_data;
  logic [AES_BLK_W-1:0] in_key;
  logic                 key_load;
  logic [AES_BLK_W-1:0] key_init;
  logic                 key_req;
  logic [AES_RND_W-1:0] key_round;
  logic                 key_ack;
  logic [AES_BLK_W-1:0] round_key;
  logic [AES_BLK_W-1:0] rf_in;
  logic                 rf_last;
  logic [AES_BLK_W-1:0] rf_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [AES_BLK_W-1:0] out_data;

  modport master (
    input  in_valid, in_data, in_key, key_ack, round_key, rf_out, out_ready,
    output in_ready, key_load, key_init, key_req, key_round, rf_in, rf_last,
           out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, in_key, key_ack, round_key, rf_out, out_ready,
    input  in_ready, key_load, key_init, key_req, key_round, rf_in, rf_last,
           out_valid, out_data
  );

endinterface

// File: rtl/ark_xor.sv
// rtl/ark_xor.sv - AddRoundKey: 128-bit state XOR round key
module ark_xor
  import aes_ctrl_pkg::*;
(
  input  logic [AES_BLK_W-1:0] blk,
  input  logic [AES_BLK_W-1:0] rkey,
  output logic [AES_BLK_W-1:0] res
);

  assign res = blk ^ rkey;

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES-128 round sequencer top; defining AES_ABORT_EN adds the abort input
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR = AES_NR
)
(
  input  logic             clk,
  input  logic             rst_n,
`ifdef AES_ABORT_EN
  input  logic             abort,
`endif
  aes_round_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(NR + 1);

  aes_fsm_e             fsm, fsm_nxt;
  logic [CNT_W-1:0]     round_cnt, round_cnt_nxt;
  logic [AES_BLK_W-1:0] state, state_nxt;
  logic [AES_BLK_W-1:0] ark_a, ark_b, ark_y;
  logic                 last_rnd;
  logic                 abort_req;

`ifdef AES_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last_rnd = (round_cnt == CNT_W'(NR));

  // Round 0 whitens the plaintext with the cipher key; later rounds add the fetched round key.
  assign ark_a = (fsm == IDLE) ? bus.in_data : bus.rf_out;
  assign ark_b = (fsm == IDLE) ? bus.in_key  : bus.round_key;

  ark_xor u_ark (
    .blk  (ark_a),
    .rkey (ark_b),
    .res  (ark_y)
  );

  assign bus.key_init = bus.in_key;
  assign bus.rf_in    = state;
  assign bus.out_data = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      round_cnt <= '0;
      state     <= '0;
    end else begin
      fsm       <= fsm_nxt;
      round_cnt <= round_cnt_nxt;
      state     <= state_nxt;
    end
  end

  always_comb begin
    fsm_nxt       = fsm;
    round_cnt_nxt = round_cnt;
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.key_load  = 1'b0;
    bus.key_req   = 1'b0;
    bus.key_round = '0;
    bus.rf_last   = 1'b0;
    bus.out_valid = 1'b0;

    case (fsm)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          bus.key_load  = 1'b1;
          state_nxt     = ark_y;
          round_cnt_nxt = CNT_W'(1);
          fsm_nxt       = ROUND;
        end
      end
      ROUND: begin
        bus.key_req   = 1'b1;
        bus.key_round = AES_RND_W'(round_cnt);
        bus.rf_last   = last_rnd;
        if (abort_req) begin
          state_nxt = '0;
          fsm_nxt   = IDLE;
        end else if (bus.key_ack) begin
          state_nxt = ark_y;
          if (last_rnd) begin
            fsm_nxt = DONE;
          end else begin
            round_cnt_nxt = round_cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (abort_req) begin
          state_nxt = '0;
          fsm_nxt   = IDLE;
        end else if (bus.out_ready) begin
          fsm_nxt = IDLE;
        end
      end
      default: fsm_nxt = IDLE;
    endcase

    // Handshake outputs drop as soon as reset is asserted, not one edge later.
    if (!rst_n) begin
      bus.in_ready  = 1'b0;
      bus.key_load  = 1'b0;
      bus.key_req   = 1'b0;
      bus.key_round = '0;
      bus.rf_last   = 1'b0;
      bus.out_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - directed FIPS-197 bench for aes_round_ctrl with reference round function and key schedule
module tb_aes_round_ctrl;
  import aes_ctrl_pkg::*;

  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ONE  = 128'd1;
  localparam logic [127:0] ZERO = 128'd0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_round_ctrl_if bus();
`ifdef AES_ABORT_EN
  logic abort;
`endif

  aes_round_ctrl #(.NR(AES_NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AES_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv, x;
    inv = 8'h01;
    x   = a;
    for (int i = 1; i < 8; i++) begin
      x   = gmul(x, x);
      inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   o [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) o[rw+4*c] = b[rw + 4*((c+rw)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = o[4*c]; a1 = o[4*c+1]; a2 = o[4*c+2]; a3 = o[4*c+3];
        o[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        o[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        o[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        o[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
    return r;
  endfunction

  function automatic logic [127:0] rk_of(input logic [127:0] k, input int rnd);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    {w0, w1, w2, w3} = k;
    rc = 8'h01;
    for (int i = 1; i <= rnd; i++) begin
      t  = {w3[23:0], w3[31:24]};
      t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rc = xt(rc);
    end
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] cur_key = '0;
  int           wait_round = 0;
  int           wait_n = 0;
  int           waited = 0;
  int           cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.key_load) cur_key <= bus.key_init;
    if (bus.key_req && !bus.key_ack) waited <= waited + 1;
    else waited <= 0;
  end

  always_comb begin
    bus.key_ack   = bus.key_req && !((int'(bus.key_round) == wait_round) && (waited < wait_n));
    bus.round_key = rk_of(cur_key, int'(bus.key_round));
    bus.rf_out    = aes_rnd(bus.rf_in, bus.rf_last);
  end

  int n_checks = 0;
  int n_pass = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] pt, input logic [127:0] key, input string tag);
    bus.in_data  = pt;
    bus.in_key   = key;
    bus.in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, 128'(bus.in_ready), ONE);
    check({tag, "_key_load"}, 128'(bus.key_load), ONE);
    check({tag, "_key_init"}, bus.key_init, key);
    acc_cyc = cyc;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check({tag, "_ark0"}, bus.rf_in, pt ^ key);
    check({tag, "_req1"}, 128'(bus.key_req), ONE);
    check({tag, "_round1"}, 128'(bus.key_round), ONE);
    check({tag, "_last1"}, 128'(bus.rf_last), ZERO);
  endtask

  task automatic finish(input logic [127:0] ct, input int lat, input string tag);
    logic         stalled;
    logic [127:0] snap_s;
    logic [3:0]   snap_r;
    while (!bus.out_valid && (cyc - acc_cyc) < 40) begin
      stalled = bus.key_req && !bus.key_ack;
      snap_s  = bus.rf_in;
      snap_r  = bus.key_round;
      if (bus.key_req && bus.key_round == 4'(AES_NR))
        check({tag, "_rf_last"}, 128'(bus.rf_last), ONE);
      tick();
      if (stalled) begin
        check({tag, "_hold_round"}, 128'(bus.key_round), 128'(snap_r));
        check({tag, "_hold_rf_in"}, bus.rf_in, snap_s);
        check({tag, "_hold_req"}, 128'(bus.key_req), ONE);
      end
    end
    check({tag, "_latency"}, 128'(cyc - acc_cyc), 128'(lat));
    check({tag, "_ct"}, bus.out_data, ct);
    check({tag, "_busy"}, 128'(bus.in_ready), ZERO);
  endtask

  int first_acc;
  int guard;
  logic seen_valid;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = PT1;
    bus.in_key    = KEY1;
    bus.out_ready = 1'b1;
`ifdef AES_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) tick();
    check("rst_in_ready", 128'(bus.in_ready), ZERO);
    check("rst_key_load", 128'(bus.key_load), ZERO);
    check("rst_key_req", 128'(bus.key_req), ZERO);
    check("rst_key_round", 128'(bus.key_round), ZERO);
    check("rst_rf_last", 128'(bus.rf_last), ZERO);
    check("rst_out_valid", 128'(bus.out_valid), ZERO);
    check("rst_out_data", bus.out_data, ZERO);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 128'(bus.in_ready), ONE);

    accept(PT1, KEY1, "c1");
    finish(CT1, 11, "c1");
    tick();

    wait_round = 5;
    wait_n     = 2;
    accept(PT1, KEY1, "wt");
    finish(CT1, 13, "wt");
    wait_n = 0;
    tick();

    bus.out_ready = 1'b0;
    accept(PT2, KEY2, "st");
    finish(CT2, 11, "st");
    bus.in_valid = 1'b1;
    bus.in_data  = PT1;
    bus.in_key   = KEY1;
    repeat (5) begin
      tick();
      check("st_out_valid", 128'(bus.out_valid), ONE);
      check("st_out_data", bus.out_data, CT2);
      check("st_in_ready", 128'(bus.in_ready), ZERO);
      check("st_key_load", 128'(bus.key_load), ZERO);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("st_idle", 128'(bus.in_ready), ONE);
    check("st_retained", bus.out_data, CT2);

    accept(PT1, KEY1, "rs");
    guard = 0;
    while (bus.key_round != 4'd3 && guard < 20) begin
      tick();
      guard++;
    end
    check("rs_at_round3", 128'(bus.key_round), 128'd3);
    rst_n = 1'b0;
    #1;
    check("rs_req_drop", 128'(bus.key_req), ZERO);
    tick();
    check("rs_in_ready", 128'(bus.in_ready), ZERO);
    check("rs_out_valid", 128'(bus.out_valid), ZERO);
    check("rs_key_round", 128'(bus.key_round), ZERO);
    check("rs_rf_last", 128'(bus.rf_last), ZERO);
    check("rs_state", bus.out_data, ZERO);
    check("rs_rf_in", bus.rf_in, ZERO);
    rst_n = 1'b1;
    #1;
    check("rs_idle", 128'(bus.in_ready), ONE);
    accept(PT2, KEY2, "rs2");
    finish(CT2, 11, "rs2");
    tick();

    accept(PT1, KEY1, "b1");
    first_acc = acc_cyc;
    finish(CT1, 11, "b1");
    tick();
    accept(PT2, KEY2, "b2");
    check("b2b_period", 128'(acc_cyc - first_acc), 128'd12);
    finish(CT2, 11, "b2");
    tick();

`ifdef AES_ABORT_EN
    accept(PT1, KEY1, "ab");
    guard = 0;
    while (bus.key_round != 4'd7 && guard < 20) begin
      tick();
      guard++;
    end
    abort = 1'b1;
    #1;
    check("ab_with_ack", 128'(bus.key_ack), ONE);
    tick();
    abort = 1'b0;
    #1;
    check("ab_idle", 128'(bus.in_ready), ONE);
    check("ab_state", bus.out_data, ZERO);
    check("ab_req", 128'(bus.key_req), ZERO);
    seen_valid = 1'b0;
    repeat (15) begin
      tick();
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check("ab_no_valid", 128'(seen_valid), ZERO);
    abort = 1'b1;
    accept(PT2, KEY2, "ai");
    abort = 1'b0;
    finish(CT2, 11, "ai");
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
